// File: rtl/fb_rect_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_rect_writer_if
// Purpose  : Bundles the rectangle command handshake, the framebuffer write
//            port and the status flags of fb_rect_writer.
// Ports    : none (signal bundle only)
//            cmd_valid/cmd_ready      command handshake
//            cmd_x/y/w/h/color        rectangle geometry and fill colour
//            write_en/addr/data       framebuffer write strobe, address, pixel
//            busy/done                status and one-cycle completion pulse
//            modport slave  : the rectangle writer side
//            modport master : the command issuer / framebuffer side
// Revision : 1.0 - initial release
// ============================================================================
interface fb_rect_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [23:0] cmd_color;
    logic        write_en;
    logic [18:0] write_addr;
    logic [23:0] write_data;
    logic        busy;
    logic        done;

    modport slave (
        input  cmd_valid,
        input  cmd_x,
        input  cmd_y,
        input  cmd_w,
        input  cmd_h,
        input  cmd_color,
        output cmd_ready,
        output write_en,
        output write_addr,
        output write_data,
        output busy,
        output done
    );

    modport master (
        output cmd_valid,
        output cmd_x,
        output cmd_y,
        output cmd_w,
        output cmd_h,
        output cmd_color,
        input  cmd_ready,
        input  write_en,
        input  write_addr,
        input  write_data,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/fb_rect_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_rect_writer
// Purpose  : Fills a clipped rectangle of a linear framebuffer with a solid
//            colour, issuing one pixel write per clock in raster order.
// Ports    : write_clk  - single rising-edge clock
//            rst_n      - asynchronous assert, active-low reset
//            bus        - fb_rect_writer_if.slave: command handshake
//                         (cmd_valid/cmd_ready, cmd_x/y/w/h/color),
//                         write port (write_en/addr/data), busy, done
// Params   : FB_WIDTH, FB_HEIGHT - framebuffer dimensions in pixels
// Revision : 1.0 - initial release
// ============================================================================
module fb_rect_writer #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480
) (
    input  logic            write_clk,
    input  logic            rst_n,
    fb_rect_writer_if.slave bus
);

    localparam logic [10:0] c_FB_W11 = 11'(FB_WIDTH);
    localparam logic [9:0]  c_FB_H10 = 10'(FB_HEIGHT);
    localparam logic [18:0] c_FB_W19 = 19'(FB_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLIP   = 2'd1,
        S_DRAW   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [9:0]  x_q,          x_d;
    logic [8:0]  y_q,          y_d;
    logic [9:0]  w_q,          w_d;
    logic [8:0]  h_q,          h_d;
    logic [23:0] color_q,      color_d;
    logic [10:0] x_end_q,      x_end_d;
    logic [9:0]  y_end_q,      y_end_d;
    logic [10:0] col_q,        col_d;
    logic [9:0]  row_q,        row_d;
    logic [18:0] row_base_q,   row_base_d;
    logic        cmd_ready_q,  cmd_ready_d;
    logic        write_en_q,   write_en_d;
    logic [18:0] write_addr_q, write_addr_d;
    logic [23:0] write_data_q, write_data_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;

    logic [10:0] w_x_sum;
    logic [9:0]  w_y_sum;
    logic [10:0] w_x_end;
    logic [9:0]  w_y_end;
    logic        w_empty;
    logic [18:0] w_y_base;
    logic [10:0] w_col_inc;
    logic [9:0]  w_row_inc;
    logic [18:0] w_next_base;

    // Clipping: sums are one bit wider than the operands so they never wrap.
    always_comb begin
        w_x_sum = {1'b0, x_q} + {1'b0, w_q};
        w_y_sum = {1'b0, y_q} + {1'b0, h_q};
        w_x_end = (w_x_sum > c_FB_W11) ? c_FB_W11 : w_x_sum;
        w_y_end = (w_y_sum > c_FB_H10) ? c_FB_H10 : w_y_sum;
        // Covers W=0, H=0 and an origin already outside the framebuffer.
        w_empty = (w_x_end <= {1'b0, x_q}) || (w_y_end <= {1'b0, y_q});
    end

    // First row base y*FB_WIDTH formed as a sum of shifted copies of the
    // constant width, so only adders appear in the datapath.
    always_comb begin
        w_y_base = '0;
        for (int i = 0; i < 9; i++) begin
            if (y_q[i]) begin
                w_y_base = w_y_base + (c_FB_W19 << i);
            end
        end
    end

    always_comb begin
        w_col_inc   = col_q + 11'd1;
        w_row_inc   = row_q + 10'd1;
        w_next_base = row_base_q + c_FB_W19;
    end

    // Next-state and registered-output logic. Every output is computed for
    // the state being entered, so the flops present it during that state.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        w_d          = w_q;
        h_d          = h_q;
        color_d      = color_q;
        x_end_d      = x_end_q;
        y_end_d      = y_end_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    x_d     = bus.cmd_x;
                    y_d     = bus.cmd_y;
                    w_d     = bus.cmd_w;
                    h_d     = bus.cmd_h;
                    color_d = bus.cmd_color;
                    state_d = S_CLIP;
                end
            end

            S_CLIP: begin
                x_end_d = w_x_end;
                y_end_d = w_y_end;
                if (w_empty) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else begin
                    state_d      = S_DRAW;
                    col_d        = {1'b0, x_q};
                    row_d        = {1'b0, y_q};
                    row_base_d   = w_y_base;
                    write_en_d   = 1'b1;
                    write_addr_d = w_y_base + {9'd0, x_q};
                    write_data_d = color_q;
                end
            end

            S_DRAW: begin
                // col_q/row_q name the pixel being written this cycle.
                if (w_col_inc < x_end_q) begin
                    col_d        = w_col_inc;
                    write_en_d   = 1'b1;
                    write_addr_d = row_base_q + {8'd0, w_col_inc};
                    write_data_d = color_q;
                end else if (w_row_inc < y_end_q) begin
                    col_d        = {1'b0, x_q};
                    row_d        = w_row_inc;
                    row_base_d   = w_next_base;
                    write_en_d   = 1'b1;
                    write_addr_d = w_next_base + {9'd0, x_q};
                    write_data_d = color_q;
                end else begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
            x_end_q      <= '0;
            y_end_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            row_base_q   <= '0;
            cmd_ready_q  <= 1'b0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            w_q          <= w_d;
            h_q          <= h_d;
            color_q      <= color_d;
            x_end_q      <= x_end_d;
            y_end_q      <= y_end_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_q   <= row_base_d;
            cmd_ready_q  <= cmd_ready_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.write_en   = write_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_rect_writer
// Purpose  : Self-checking bench for fb_rect_writer. A 640x480 instance runs
//            the directed geometry cases; a 32x16 instance runs the full-clear
//            and held-valid back-to-back case at a size that keeps the run
//            short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_rect_writer;

    localparam int c_BW = 640;
    localparam int c_BH = 480;
    localparam int c_SW = 32;
    localparam int c_SH = 16;

    typedef struct packed {
        logic        we;
        logic [18:0] addr;
        logic [23:0] data;
        logic        busy;
        logic        done;
        logic        ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_rect_writer_if bus0 ();
    fb_rect_writer_if bus1 ();

    fb_rect_writer #(.FB_WIDTH(c_BW), .FB_HEIGHT(c_BH)) u_dut (
        .write_clk (clk),
        .rst_n     (rst_n),
        .bus       (bus0)
    );

    fb_rect_writer #(.FB_WIDTH(c_SW), .FB_HEIGHT(c_SH)) u_small (
        .write_clk (clk),
        .rst_n     (rst_n),
        .bus       (bus1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rst_tail = 1'b1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [18:0] obs0[$];
    logic [23:0] obs0d[$];
    logic [18:0] obs1[$];
    int acc_cyc0, acc_cyc1, first_we0, last_we0, done_cyc0, done_cyc1;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int busy_cnt0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp_v, exp_v, cyc);
        end
    endtask

    function automatic void push_exp(input int inst, input exp_t e);
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endfunction

    // Model: clip with plain arithmetic and enumerate every pixel in raster
    // order, producing the expected outputs cycle by cycle after acceptance.
    function automatic void build(input int inst, input int x, input int y,
                                  input int w, input int h, input logic [23:0] col);
        int fbw, fbh, xe, ye;
        exp_t e;
        fbw = (inst == 0) ? c_BW : c_SW;
        fbh = (inst == 0) ? c_BH : c_SH;
        xe  = (x + w < fbw) ? x + w : fbw;
        ye  = (y + h < fbh) ? y + h : fbh;
        e = '{we:1'b0, addr:19'd0, data:24'd0, busy:1'b1, done:1'b0, ready:1'b0};
        push_exp(inst, e);
        for (int r = y; r < ye; r++) begin
            for (int c = x; c < xe; c++) begin
                e.we   = 1'b1;
                e.addr = 19'(r * fbw + c);
                e.data = col;
                push_exp(inst, e);
            end
        end
        e.we   = 1'b0;
        e.done = 1'b1;
        push_exp(inst, e);
    endfunction

    task automatic check_inst(input int inst, input bit rmode);
        exp_t        e;
        logic        we, busy, done, ready, valid;
        logic [18:0] addr;
        logic [23:0] data, cc;
        logic [9:0]  cx, cw;
        logic [8:0]  cy, ch;
        string       p;
        p = $sformatf("i%0d", inst);
        if (inst == 0) begin
            we = bus0.write_en; busy = bus0.busy; done = bus0.done;
            ready = bus0.cmd_ready; valid = bus0.cmd_valid;
            addr = bus0.write_addr; data = bus0.write_data;
            cx = bus0.cmd_x; cy = bus0.cmd_y; cw = bus0.cmd_w; ch = bus0.cmd_h;
            cc = bus0.cmd_color;
        end else begin
            we = bus1.write_en; busy = bus1.busy; done = bus1.done;
            ready = bus1.cmd_ready; valid = bus1.cmd_valid;
            addr = bus1.write_addr; data = bus1.write_data;
            cx = bus1.cmd_x; cy = bus1.cmd_y; cw = bus1.cmd_w; ch = bus1.cmd_h;
            cc = bus1.cmd_color;
        end
        if (rmode) begin
            chk({p, "_rst_we"},    32'(we),    32'd0);
            chk({p, "_rst_busy"},  32'(busy),  32'd0);
            chk({p, "_rst_done"},  32'(done),  32'd0);
            chk({p, "_rst_ready"}, 32'(ready), 32'd0);
            chk({p, "_rst_addr"},  32'(addr),  32'd0);
            chk({p, "_rst_data"},  32'(data),  32'd0);
        end else begin
            e = '{we:1'b0, addr:19'd0, data:24'd0, busy:1'b0, done:1'b0, ready:1'b1};
            if (inst == 0) begin
                if (q0.size() != 0) e = q0.pop_front();
            end else begin
                if (q1.size() != 0) e = q1.pop_front();
            end
            chk({p, "_we"},    32'(we),    32'(e.we));
            chk({p, "_busy"},  32'(busy),  32'(e.busy));
            chk({p, "_done"},  32'(done),  32'(e.done));
            chk({p, "_ready"}, 32'(ready), 32'(e.ready));
            if (e.we) begin
                chk({p, "_addr"}, 32'(addr), 32'(e.addr));
                chk({p, "_data"}, 32'(data), 32'(e.data));
            end
            if (e.ready && valid) begin
                build(inst, int'(cx), int'(cy), int'(cw), int'(ch), cc);
                if (inst == 0) acc_cyc0 = cyc;
                else           acc_cyc1 = cyc;
            end
            if (inst == 0) begin
                if (we) begin
                    if (obs0.size() == 0) first_we0 = cyc;
                    last_we0 = cyc;
                    obs0.push_back(addr);
                    obs0d.push_back(data);
                end
                if (done) begin done_cnt0++; done_cyc0 = cyc; end
                if (busy) busy_cnt0++;
            end else begin
                if (we) obs1.push_back(addr);
                if (done) begin done_cnt1++; done_cyc1 = cyc; end
            end
        end
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        bit rm;
        cyc++;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            rst_tail = 1'b1;
        end
        rm = !rst_n || rst_tail;
        check_inst(0, rm);
        check_inst(1, rm);
        if (rst_n) rst_tail = 1'b0;
    end

    task automatic drive(input int inst, input logic v, input int x, input int y,
                         input int w, input int h, input logic [23:0] col);
        if (inst == 0) begin
            bus0.cmd_valid = v; bus0.cmd_x = 10'(x); bus0.cmd_y = 9'(y);
            bus0.cmd_w = 10'(w); bus0.cmd_h = 9'(h); bus0.cmd_color = col;
        end else begin
            bus1.cmd_valid = v; bus1.cmd_x = 10'(x); bus1.cmd_y = 9'(y);
            bus1.cmd_w = 10'(w); bus1.cmd_h = 9'(h); bus1.cmd_color = col;
        end
    endtask

    function automatic logic rdy(input int inst);
        return (inst == 0) ? bus0.cmd_ready : bus1.cmd_ready;
    endfunction

    // Offer a command and return just after the edge that accepts it. Unless
    // held, the fields are scrambled afterwards to show they were latched.
    task automatic send(input int inst, input int x, input int y, input int w,
                        input int h, input logic [23:0] col, input bit hold);
        int n;
        n = 0;
        @(posedge clk); #1;
        drive(inst, 1'b1, x, y, w, h, col);
        @(negedge clk);
        while (!rdy(inst) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rdy(inst)) begin
            errors++;
            $display("FAIL accept_timeout: inst %0d cmd_ready stayed 0, required 1", inst);
        end
        @(posedge clk); #1;
        if (!hold) drive(inst, 1'b0, 1023, 511, 1023, 511, 24'h5A5A5A);
    endtask

    task automatic wait_done(input int inst, input int limit);
        int start, n;
        start = (inst == 0) ? done_cnt0 : done_cnt1;
        n = 0;
        while ((((inst == 0) ? done_cnt0 : done_cnt1) == start) && n < limit) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (((inst == 0) ? done_cnt0 : done_cnt1) == start) begin
            errors++;
            $display("FAIL done_timeout: inst %0d no DONE within %0d cycles, required 1 pulse", inst, limit);
        end
    endtask

    task automatic clear_obs();
        obs0.delete();
        obs0d.delete();
        busy_cnt0 = 0;
        first_we0 = -1;
        last_we0  = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [18:0] a031 [6];
        int bad, done_before;
        a031 = '{19'd1290, 19'd1291, 19'd1292, 19'd1930, 19'd1931, 19'd1932};
        drive(0, 1'b0, 0, 0, 0, 0, 24'h0);
        drive(1, 1'b0, 0, 0, 0, 0, 24'h0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 3x2 rectangle inside the frame
        clear_obs();
        send(0, 10, 2, 3, 2, 24'hFF00FF, 1'b0);
        wait_done(0, 100);
        chk("r031_count", 32'(obs0.size()), 32'd6);
        for (int i = 0; i < 6 && i < obs0.size(); i++) begin
            chk($sformatf("r031_addr%0d", i), 32'(obs0[i]), 32'(a031[i]));
            chk($sformatf("r031_data%0d", i), 32'(obs0d[i]), 32'h00FF00FF);
        end
        chk("r031_first_we_latency", 32'(first_we0 - acc_cyc0), 32'd2);
        chk("r031_done_after_last", 32'(done_cyc0 - last_we0), 32'd1);

        // bottom-right corner, clipped both ways
        clear_obs();
        send(0, 638, 479, 5, 4, 24'h00A0B0, 1'b0);
        wait_done(0, 100);
        chk("r032_count", 32'(obs0.size()), 32'd2);
        if (obs0.size() == 2) begin
            chk("r032_addr0", 32'(obs0[0]), 32'd307198);
            chk("r032_addr1", 32'(obs0[1]), 32'd307199);
        end

        // zero width
        clear_obs();
        send(0, 20, 20, 0, 5, 24'h111111, 1'b0);
        wait_done(0, 100);
        chk("w0_count", 32'(obs0.size()), 32'd0);
        chk("w0_done_latency", 32'(done_cyc0 - acc_cyc0), 32'd2);
        chk("w0_busy_cycles", 32'(busy_cnt0), 32'd2);

        // origin past the right edge
        clear_obs();
        send(0, 700, 10, 4, 4, 24'h222222, 1'b0);
        wait_done(0, 100);
        chk("x700_count", 32'(obs0.size()), 32'd0);
        chk("x700_done_latency", 32'(done_cyc0 - acc_cyc0), 32'd2);
        chk("x700_busy_cycles", 32'(busy_cnt0), 32'd2);

        // bottom clip and single right-edge pixel
        clear_obs();
        send(0, 5, 470, 3, 20, 24'h123456, 1'b0);
        wait_done(0, 200);
        chk("yclip_count", 32'(obs0.size()), 32'd30);
        clear_obs();
        send(0, 639, 0, 1, 1, 24'hABCDEF, 1'b0);
        wait_done(0, 100);
        chk("edge_count", 32'(obs0.size()), 32'd1);
        if (obs0.size() == 1) chk("edge_addr", 32'(obs0[0]), 32'd639);

        // full clear of the small frame with valid held and new fields queued
        obs1.delete();
        send(1, 0, 0, c_SW, c_SH, 24'hC0FFEE, 1'b1);
        drive(1, 1'b1, 30, 14, 5, 5, 24'h0BEEF0);
        wait_done(1, 2000);
        chk("clear_count", 32'(obs1.size()), 32'(c_SW * c_SH));
        bad = 0;
        for (int i = 0; i < obs1.size(); i++) begin
            if (int'(obs1[i]) != i) bad++;
        end
        chk("clear_contiguous_errs", 32'(bad), 32'd0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus1.cmd_ready && n < 100) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            drive(1, 1'b0, 0, 0, 0, 0, 24'h0);
        end
        chk("second_accept_after_done", 32'(acc_cyc1 - done_cyc1), 32'd1);
        wait_done(1, 100);
        chk("second_count", 32'(obs1.size()), 32'(c_SW * c_SH + 4));

        // reset in the middle of a 10x10 fill
        done_before = done_cnt0;
        send(0, 100, 100, 10, 10, 24'h777777, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        chk("we_before_rst", 32'(bus0.write_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("we_async_drop", 32'(bus0.write_en), 32'd0);
        chk("busy_async_drop", 32'(bus0.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(bus0.cmd_ready), 32'd1);
        chk("no_done_after_abort", 32'(done_cnt0), 32'(done_before));

        clear_obs();
        send(0, 1, 1, 2, 2, 24'h00FF00, 1'b0);
        wait_done(0, 100);
        chk("post_rst_count", 32'(obs0.size()), 32'd4);
        if (obs0.size() == 4) begin
            chk("post_rst_addr0", 32'(obs0[0]), 32'd641);
            chk("post_rst_addr3", 32'(obs0[3]), 32'd1282);
        end

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_rect_writer.md
FB_RECT_WRITER -- requirements
Module: fb_rect_writer

Interface
REQ-001 Parameter FB_WIDTH, default 640, framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, default 480, framebuffer height in pixels.
REQ-003 WRITE_CLK  input  1  single clock; all logic rising-edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 CMD_VALID  input  1  rectangle command offered.
REQ-006 CMD_READY  output  1  block can accept a command.
REQ-007 CMD_X  input  10  left column. CMD_Y  input  9  top row.
REQ-008 CMD_W  input  10  width in pixels. CMD_H  input  9  height in pixels.
REQ-009 CMD_COLOR  input  24  fill colour {R,G,B}.
REQ-010 WRITE_EN  output  1  write strobe to the framebuffer write port.
REQ-011 WRITE_ADDR  output  19  linear pixel address, y*FB_WIDTH+x.
REQ-012 WRITE_DATA  output  24  pixel colour.
REQ-013 BUSY  output  1  command in progress. DONE  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states IDLE, CLIP, DRAW, FINISH; all outputs registered.
REQ-015 CMD_READY SHALL be 1 only in IDLE; a command is accepted on a rising edge where CMD_VALID & CMD_READY.
REQ-016 On accept, all CMD_* fields SHALL be latched; input changes afterwards have no effect; next state CLIP.
REQ-017 CLIP (one cycle): x_end=min(CMD_X+CMD_W, FB_WIDTH), y_end=min(CMD_Y+CMD_H, FB_HEIGHT), sums computed 11/10 bits wide, no overflow.
REQ-018 Zero-area after clipping (W=0, H=0, X>=FB_WIDTH or Y>=FB_HEIGHT): CLIP->FINISH, no writes issued.
REQ-019 Otherwise CLIP->DRAW; first WRITE_EN asserted in the cycle 2 clocks after accept edge.
REQ-020 DRAW: one pixel per cycle, WRITE_EN=1 continuously, raster order: columns X..x_end-1 within row, rows Y..y_end-1.
REQ-021 WRITE_ADDR generated incrementally (row_base += FB_WIDTH at row end, addr = row_base + col); no multiplier in the datapath.
REQ-022 WRITE_DATA = latched CMD_COLOR for every write.
REQ-023 Writes issued = (x_end-X)*(y_end-Y) exactly; no address >= FB_WIDTH*FB_HEIGHT ever produced.
REQ-024 After last pixel, DRAW->FINISH; FINISH asserts DONE for exactly one cycle with WRITE_EN=0, then IDLE.
REQ-025 BUSY = 1 in CLIP, DRAW, FINISH; 0 in IDLE.
REQ-026 CMD_VALID during BUSY SHALL be ignored (held off by CMD_READY=0); earliest next accept is the cycle after DONE.
REQ-027 WRITE_EN=0 in IDLE, CLIP, FINISH.

Reset
REQ-028 RST_N low SHALL immediately force IDLE, CMD_READY=0, WRITE_EN=0, BUSY=0, DONE=0, WRITE_ADDR=0, WRITE_DATA=0.
REQ-029 CMD_READY SHALL rise on the first WRITE_CLK edge after RST_N deasserts.
REQ-030 Reset during DRAW SHALL abort the command; no further writes and no DONE for it.

Verification
REQ-031 Cmd X=10,Y=2,W=3,H=2,COLOR=FF00FF -> 6 writes, addrs 1290,1291,1292,1930,1931,1932, data FF00FF, first write 2 cycles after accept, DONE 1 cycle after last write.
REQ-032 Cmd X=638,Y=479,W=5,H=4 -> clipped to 2 writes, addrs 307198,307199, then DONE.
REQ-033 Cmd W=0,H=5 and cmd X=700 -> zero writes, DONE pulse 2 cycles after accept, BUSY high 2 cycles.
REQ-034 Full clear X=0,Y=0,W=640,H=480 -> 307200 consecutive writes, addrs 0..307199 contiguous, CMD_VALID held high throughout with new fields -> second command accepted only after DONE.
REQ-035 RST_N low mid-DRAW of 10x10 rect -> WRITE_EN drops asynchronously, no DONE, CMD_READY=1 one clock after release, next command executes normally.
